boot_loader: RTL and testbench



---
 rtl/boot_loader.sv | 122 ++++++++++++
 tb/tb_boot_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: assembles little-endian words from a byte stream and drives the CPU boot port.
// Define BOOT_CHECKSUM_EN to require a trailing 32-bit XOR checksum (CHK state) before release.
module boot_loader #(
  parameter logic [31:0] BOOT_BASE      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 4096,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        boot_req,
  output logic [31:0] boot_addr,
  output logic [31:0] boot_data,
  output logic        boot_we,
  output logic        debug,
  output logic        boot_done,
  output logic        boot_err
);

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
  localparam state_t S_LOAD_END = S_CHK;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_LOAD_END = S_DONE;
`endif

  state_t      state, state_nx;
  logic [1:0]  byte_idx;
  logic [23:0] shift;
  logic [31:0] n_words, word_cnt, tmo_cnt, word;
  logic        rdy_q, acc, word_end, loading, tmo_hit;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] xor_acc;
`endif

  // A restart request wins over a byte offered in the same cycle.
  assign rx_ready = rdy_q & ~boot_req;
  assign acc      = rx_valid & rx_ready;
  assign word_end = acc & (byte_idx == 2'd3);
  assign word     = {rx_data, shift};
  assign loading  = (state != S_DONE) && (state != S_ERR);
  assign tmo_hit  = loading && !acc && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (boot_req) begin
      state_nx = S_LEN;
    end else if (tmo_hit) begin
      state_nx = S_ERR;
    end else if (word_end) begin
      case (state)
        S_LEN: begin
          if (word == '0)                  state_nx = S_LOAD_END;
          else if (word > 32'(MAX_WORDS))  state_nx = S_ERR;
          else                             state_nx = S_DATA;
        end
        S_DATA: if (word_cnt + 32'd1 == n_words) state_nx = S_LOAD_END;
`ifdef BOOT_CHECKSUM_EN
        S_CHK:  state_nx = (word == xor_acc) ? S_DONE : S_ERR;
`endif
        default: state_nx = state;
      endcase
    end
  end

  // Control and boot-port outputs; all status outputs follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= '0;
      word_cnt  <= '0;
      tmo_cnt   <= '0;
      rdy_q     <= 1'b1;
      boot_addr <= BOOT_BASE;
      boot_data <= '0;
      boot_we   <= 1'b0;
      debug     <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      boot_we   <= 1'b0;
      rdy_q     <= (state_nx != S_DONE) && (state_nx != S_ERR);
      debug     <= (state_nx != S_DONE);
      boot_done <= (state_nx == S_DONE);
      boot_err  <= (state_nx == S_ERR);
      if (boot_req) begin
        byte_idx  <= '0;
        word_cnt  <= '0;
        tmo_cnt   <= '0;
        boot_addr <= BOOT_BASE;
      end else begin
        if (acc) byte_idx <= byte_idx + 2'd1;
        if (acc || (state_nx != state)) tmo_cnt <= '0;
        else if (loading)               tmo_cnt <= tmo_cnt + 32'd1;
        if ((state == S_DATA) && word_end) begin
          boot_addr <= BOOT_BASE + {word_cnt[29:0], 2'b00};
          boot_data <= word;
          boot_we   <= 1'b1;
          word_cnt  <= word_cnt + 32'd1;
        end
      end
    end
  end

  // Byte assembly; LSB arrives first so bytes shift in from the top.
  always_ff @(posedge clk) begin
    if (acc) shift <= {rx_data, shift[23:8]};
    if ((state == S_LEN) && word_end) n_words <= word;
`ifdef BOOT_CHECKSUM_EN
    if (state == S_LEN)                       xor_acc <= '0;
    else if ((state == S_DATA) && word_end)   xor_acc <= xor_acc ^ word;
`endif
  end

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader with a byte-queue reference model and directed literal checks.
module tb_boot_loader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int MAXW = 4096;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        rst, rx_valid, boot_req;
  logic [7:0]  rx_data;
  logic        rx_ready, boot_we, debug, boot_done, boot_err;
  logic [31:0] boot_addr, boot_data;

  boot_loader #(.BOOT_BASE(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_data(boot_data), .boot_we(boot_we),
    .debug(debug), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: every accepted byte since the last restart, plus derived outputs.
  logic [7:0]  got[$];
  logic [31:0] m_n, m_addr, m_data, m_xor;
  bit          m_we, m_done, m_err;
  int          m_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wd(input int pos);
    return {got[pos+3], got[pos+2], got[pos+1], got[pos]};
  endfunction

  function automatic bit m_ready();
    return !m_done && !m_err;
  endfunction

  function automatic void end_of_image();
`ifndef BOOT_CHECKSUM_EN
    m_done = 1'b1;
`endif
  endfunction

  task automatic model_reset();
    got.delete();
    m_idle = 0; m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
    m_addr = BASE; m_data = '0; m_xor = '0; m_n = '0;
  endtask

  task automatic model_edge(input bit acc, input bit req, input logic [7:0] d);
    int nb;
    logic [31:0] k;
    m_we = 1'b0;
    if (req) begin
      got.delete();
      m_idle = 0; m_done = 1'b0; m_err = 1'b0; m_addr = BASE; m_xor = '0;
    end else if (m_ready()) begin
      if (acc) begin
        got.push_back(d);
        m_idle = 0;
        nb = got.size();
        if (nb == 4) begin
          m_n = wd(0);
          if (m_n == 0)               end_of_image();
          else if (m_n > 32'(MAXW))   m_err = 1'b1;
        end else if (nb % 4 == 0) begin
          k = 32'(nb / 4 - 2);
          if (k < m_n) begin
            m_data = wd(nb - 4);
            m_addr = BASE + 32'd4 * k;
            m_we   = 1'b1;
            m_xor  = m_xor ^ m_data;
            if (k + 1 == m_n) end_of_image();
          end else if (wd(nb - 4) == m_xor) begin
            m_done = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) m_err = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("rx_ready",  32'(rx_ready),  32'(m_ready() && !boot_req));
      check("boot_we",   32'(boot_we),   32'(m_we));
      check("boot_addr", boot_addr,      m_addr);
      check("boot_data", boot_data,      m_data);
      check("debug",     32'(debug),     32'(!m_done));
      check("boot_done", 32'(boot_done), 32'(m_done));
      check("boot_err",  32'(boot_err),  32'(m_err));
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit req);
    bit acc;
    rx_valid = v; rx_data = d; boot_req = req;
    acc = v && m_ready() && !req;
    @(posedge clk);
    model_edge(acc, req, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) cyc(1'b1, w[8*b +: 8], 1'b0);
  endtask

  task automatic send_word_r(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      if (!m_ready()) return;
      idle(($urandom_range(0, 49) == 0) ? 20 : int'($urandom_range(0, 3)));
      if ($urandom_range(0, 99) == 0) cyc(1'b1, 8'($urandom), 1'b1);
      cyc(1'b1, w[8*b +: 8], 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; boot_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst rx_ready", 32'(rx_ready), 32'd1);
    check("rst debug", 32'(debug), 32'd1);
    check("rst boot_addr", boot_addr, BASE);
    check("rst boot_data", boot_data, 32'd0);
    check("rst boot_we", 32'(boot_we), 32'd0);
    check("rst boot_done", 32'(boot_done), 32'd0);
    check("rst boot_err", 32'(boot_err), 32'd0);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;

    // Two-word image
    send_word(32'd2);
    send_word(32'h0000_0013);
    check("w0 we", 32'(boot_we), 32'd1);
    check("w0 addr", boot_addr, 32'h0000_1000);
    check("w0 data", boot_data, 32'h0000_0013);
    send_word(32'h0010_0073);
    check("w1 addr", boot_addr, 32'h0000_1004);
    check("w1 data", boot_data, 32'h0010_0073);
`ifdef BOOT_CHECKSUM_EN
    check("pre-chk debug", 32'(debug), 32'd1);
    send_word(32'h0010_0060);
`endif
    check("img debug", 32'(debug), 32'd0);
    check("img done", 32'(boot_done), 32'd1);
    repeat (3) cyc(1'b1, 8'hAA, 1'b0);
    check("done holds addr", boot_addr, 32'h0000_1004);

    // Empty image
    cyc(1'b0, 8'h00, 1'b1);
    send_word(32'd0);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'd0);
`endif
    check("empty done", 32'(boot_done), 32'd1);
    check("empty addr", boot_addr, BASE);

    // Oversized count, then restart with a byte offered alongside the request
    cyc(1'b0, 8'h00, 1'b1);
    send_word(32'h0000_1001);
    check("big err", 32'(boot_err), 32'd1);
    check("big debug", 32'(debug), 32'd1);
    check("big rx_ready", 32'(rx_ready), 32'd0);
    repeat (3) cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b1, 8'h55, 1'b1);
    check("req clears err", 32'(boot_err), 32'd0);
    check("req debug", 32'(debug), 32'd1);
    send_word(32'd4096);
    send_word(32'h1111_2222);
    send_word(32'hDEAD_BEEF);
    check("max ok err", 32'(boot_err), 32'd0);
    check("max addr", boot_addr, 32'h0000_1004);
    check("max data", boot_data, 32'hDEAD_BEEF);

    // Timeout in the middle of the first data word
    cyc(1'b0, 8'h00, 1'b1);
    send_word(32'd2);
    cyc(1'b1, 8'h13, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    idle(TMO - 1);
    check("tmo not yet", 32'(boot_err), 32'd0);
    idle(1);
    check("tmo err", 32'(boot_err), 32'd1);
    repeat (2) cyc(1'b1, 8'h00, 1'b0);
    check("tmo no write", 32'(boot_we), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    cyc(1'b0, 8'h00, 1'b1);
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0073);
    send_word(32'h0010_0061);
    check("bad chk err", 32'(boot_err), 32'd1);
`endif

    // Asynchronous reset in the data phase, then a full reload
    cyc(1'b0, 8'h00, 1'b1);
    send_word(32'd2);
    send_word(32'h0000_0013);
    #2 rst = 1'b1;
    #1;
    check("arst debug", 32'(debug), 32'd1);
    check("arst addr", boot_addr, BASE);
    check("arst data", boot_data, 32'd0);
    check("arst we", 32'(boot_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0073);
`ifdef BOOT_CHECKSUM_EN
    send_word(32'h0010_0060);
`endif
    check("reload done", 32'(boot_done), 32'd1);
    check("reload addr", boot_addr, 32'h0000_1004);

    // Randomized loads
    for (int ld = 0; ld < 40; ld++) begin
      logic [31:0] n, w, x;
      int sel;
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      sel = int'($urandom_range(0, 19));
      n = (sel == 0) ? 32'(MAXW + 1) : (sel == 1) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 5));
      x = '0;
      send_word_r(n);
      for (int i = 0; i < 6 && 32'(i) < n && m_ready(); i++) begin
        w = $urandom;
        x = x ^ w;
        send_word_r(w);
      end
`ifdef BOOT_CHECKSUM_EN
      send_word_r(($urandom_range(0, 3) == 0) ? (x ^ 32'd1) : x);
`endif
      repeat (3) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
